// File: rtl/snow_pkg.sv
// ============================================================================
// snow_pkg -- shared SNOW FSM types, defaults and GF(2^8) helpers | rev 1.0
// ============================================================================
`default_nettype none

package snow_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int c_w_default          = 32;
  localparam int c_init_words_default = 32;
  localparam int c_init_words_max     = 255;
  localparam int c_num_r_snow2        = 2;
  localparam int c_num_r_snow3g       = 3;

  // Multiply by x; c is the low byte of the field polynomial.
  function automatic logic [7:0] gf_mulx(input logic [7:0] v, input logic [7:0] c);
    return {v[6:0], 1'b0} ^ (v[7] ? c : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] t;
    acc = 8'h00;
    t   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ t;
      t = gf_mulx(t, c);
    end
    return acc;
  endfunction

  // Column mix shared by S1 and S2; byte 0 is the most significant byte.
  function automatic logic [31:0] mix_col(input logic [31:0] s, input logic [7:0] c);
    logic [7:0] s0, s1, s2, s3, r0, r1, r2, r3;
    {s0, s1, s2, s3} = s;
    r0 = gf_mulx(s0, c) ^ s1 ^ s2 ^ gf_mulx(s3, c) ^ s3;
    r1 = gf_mulx(s0, c) ^ s0 ^ gf_mulx(s1, c) ^ s2 ^ s3;
    r2 = s0 ^ gf_mulx(s1, c) ^ s1 ^ gf_mulx(s2, c) ^ s3;
    r3 = s0 ^ s1 ^ gf_mulx(s2, c) ^ s2 ^ gf_mulx(s3, c);
    return {r0, r1, r2, r3};
  endfunction

endpackage

`default_nettype wire

// File: rtl/S_Box.sv
// ============================================================================
// S_Box -- SNOW S1: AES byte substitution followed by the AES column mix | rev 1.0
// ============================================================================
`default_nettype none

module S_Box
  import snow_pkg::*;
(
  input  logic [31:0] i_w,
  output logic [31:0] o_r
);

  // Inverse as x^254 by square-and-multiply, then the AES affine map.
  function automatic logic [7:0] aes_sr(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] t;
    inv = 8'h01;
    t   = x;
    for (int i = 0; i < 7; i++) begin
      t   = gf_mul(t, t, 8'h1B);
      inv = gf_mul(inv, t, 8'h1B);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [31:0] w_sub;

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign w_sub[8*b +: 8] = aes_sr(i_w[8*b +: 8]);
  end

  assign o_r = mix_col(w_sub, 8'h1B);

endmodule

`default_nettype wire

// File: rtl/snow_s2_box.sv
// ============================================================================
// snow_s2_box -- SNOW 3G S2: Dickson SQ substitution and column mix over 0x169 | rev 1.0
// ============================================================================
`default_nettype none

module snow_s2_box
  import snow_pkg::*;
(
  input  logic [31:0] i_w,
  output logic [31:0] o_r
);

  function automatic logic [7:0] sq(input logic [7:0] x);
    logic [7:0] x2, x4, x8, x9, x13, x15, x16, x32, x33, x41, x45, x47, x49;
    x2  = gf_mul(x,   x,   8'h69);
    x4  = gf_mul(x2,  x2,  8'h69);
    x8  = gf_mul(x4,  x4,  8'h69);
    x9  = gf_mul(x8,  x,   8'h69);
    x13 = gf_mul(x9,  x4,  8'h69);
    x15 = gf_mul(x13, x2,  8'h69);
    x16 = gf_mul(x8,  x8,  8'h69);
    x32 = gf_mul(x16, x16, 8'h69);
    x33 = gf_mul(x32, x,   8'h69);
    x41 = gf_mul(x33, x8,  8'h69);
    x45 = gf_mul(x41, x4,  8'h69);
    x47 = gf_mul(x45, x2,  8'h69);
    x49 = gf_mul(x47, x2,  8'h69);
    return x ^ x9 ^ x13 ^ x15 ^ x33 ^ x41 ^ x45 ^ x47 ^ x49 ^ 8'h25;
  endfunction

  logic [31:0] w_sub;

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign w_sub[8*b +: 8] = sq(i_w[8*b +: 8]);
  end

  assign o_r = mix_col(w_sub, 8'h69);

endmodule

`default_nettype wire

// File: rtl/snow_fsm_core.sv
// ============================================================================
// snow_fsm_core -- SNOW 2.0 / SNOW 3G FSM with valid/ready handshake | rev 1.0
// ============================================================================
`default_nettype none

module snow_fsm_core
  import snow_pkg::*;
#(
  parameter int NUM_R      = c_num_r_snow2,
  parameter int INIT_WORDS = c_init_words_default,
  parameter int W          = c_w_default
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] s15,
  input  logic [W-1:0] s5,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] f_out,
  output logic         f_init,
  output logic         busy
);

  localparam logic [7:0] c_init_last = 8'(INIT_WORDS);

  if (NUM_R != c_num_r_snow2 && NUM_R != c_num_r_snow3g) begin : g_bad_num_r
    $error("snow_fsm_core: NUM_R must be 2 or 3");
  end
  if (W != 32) begin : g_bad_w
    $error("snow_fsm_core: S-box modes require W == 32");
  end
  if (INIT_WORDS < 1 || INIT_WORDS > c_init_words_max) begin : g_bad_init_words
    $error("snow_fsm_core: INIT_WORDS must be in 1..255");
  end

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_r1;
  logic [W-1:0] r_r2;
  logic [W-1:0] w_r1_nxt;
  logic [W-1:0] w_s1;
  logic [W-1:0] w_f;
  logic [W-1:0] r_f_out;
  logic [7:0]   r_cnt;
  logic [7:0]   w_cnt_inc;
  logic         r_out_valid;
  logic         r_f_init;
  logic         w_xfer;
  logic         w_in_init;

  assign in_ready  = (r_state != ST_IDLE) && (!r_out_valid || out_ready);
  // start wins over a coincident pair so the new session begins from cleared registers.
  assign w_xfer    = in_valid && in_ready && !start;
  assign w_in_init = (r_state == ST_INIT);
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_f       = (s15 + r_r1) ^ r_r2;

  S_Box u_s1 (
    .i_w(r_r1),
    .o_r(w_s1)
  );

  if (NUM_R == c_num_r_snow3g) begin : g_snow3g
    logic [W-1:0] r_r3;
    logic [W-1:0] w_s2;

    snow_s2_box u_s2 (
      .i_w(r_r2),
      .o_r(w_s2)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_r3 <= '0;
      end else if (start) begin
        r_r3 <= '0;
      end else if (w_xfer) begin
        r_r3 <= w_s2;
      end
    end

    assign w_r1_nxt = r_r2 + (r_r3 ^ s5);
  end else begin : g_snow2
    assign w_r1_nxt = s5 + r_r2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = ST_INIT;
    end else if (w_in_init && w_xfer && (w_cnt_inc == c_init_last)) begin
      w_state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r1        <= '0;
      r_r2        <= '0;
      r_cnt       <= 8'd0;
      r_out_valid <= 1'b0;
      r_f_out     <= '0;
      r_f_init    <= 1'b0;
    end else if (start) begin
      r_r1        <= '0;
      r_r2        <= '0;
      r_cnt       <= 8'd0;
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_r1        <= w_r1_nxt;
      r_r2        <= w_s1;
      r_f_out     <= w_f;
      r_f_init    <= w_in_init;
      r_out_valid <= 1'b1;
      if (w_in_init) begin
        r_cnt <= w_cnt_inc;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign f_out     = r_f_out;
  assign f_init    = r_f_init;
  assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire
